// File: rtl/multiplier_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : multiplier_sequencer_if
//  Description : Bundles the sequencer's handshake, operand and shift-register
//                control signals. The master side is the system plus the two
//                shift registers; the slave side is the sequencer itself.
//  Revision    : 1.0 - initial release
// ============================================================================
interface multiplier_sequencer_if #(
   parameter int WORD_LENGTH = 4,
   parameter int WORD        = WORD_LENGTH * 2
);
   // system handshake and operands
   logic                   start;
   logic [WORD_LENGTH-1:0] multiplicand;
   logic [WORD_LENGTH-1:0] multiplier;

   // feedback from the shift registers
   logic [WORD-1:0]        multiplicandShifted;
   logic                   multiplierBit;

   // control towards the shift registers
   logic [WORD_LENGTH-1:0] multiplicandLoad;
   logic [WORD_LENGTH-1:0] multiplierLoad;
   logic                   load;
   logic                   shift;

   // result and status towards the system
   logic [WORD-1:0]        product;
   logic                   ready;
   logic                   busy;

   modport master (
      output start,
      output multiplicand,
      output multiplier,
      output multiplicandShifted,
      output multiplierBit,
      input  multiplicandLoad,
      input  multiplierLoad,
      input  load,
      input  shift,
      input  product,
      input  ready,
      input  busy
   );

   modport slave (
      input  start,
      input  multiplicand,
      input  multiplier,
      input  multiplicandShifted,
      input  multiplierBit,
      output multiplicandLoad,
      output multiplierLoad,
      output load,
      output shift,
      output product,
      output ready,
      output busy
   );
endinterface
`default_nettype wire

// File: rtl/multiplier_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : multiplier_sequencer
//  Description : Control and accumulate stage of a shift-and-add multiplier.
//                Loads the external left (multiplicand) and right (multiplier)
//                shift registers, shifts them WORD_LENGTH times and adds the
//                left register's value into the accumulator whenever the right
//                register's LSB is set. Start/ready handshake to the system.
//  Revision    : 1.0 - initial release
// ============================================================================
module multiplier_sequencer #(
   parameter int WORD_LENGTH = 4,
   parameter int WORD        = WORD_LENGTH * 2,
   parameter int COUNT_WIDTH = $clog2(WORD_LENGTH + 1)
) (
   input  wire logic             clk,
   input  wire logic             reset,
   multiplier_sequencer_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_CALC = 2'd2,
      S_DONE = 2'd3
   } state_t;

   localparam logic [COUNT_WIDTH-1:0] c_LAST_ITER = COUNT_WIDTH'(WORD_LENGTH - 1);

   state_t                 r_state;
   state_t                 w_nextState;
   logic [COUNT_WIDTH-1:0] r_counter;
   logic [WORD-1:0]        r_acc;
   logic [WORD-1:0]        r_product;
   logic [WORD_LENGTH-1:0] r_multiplicandLoad;
   logic [WORD_LENGTH-1:0] r_multiplierLoad;
   logic                   w_lastIter;
   logic                   w_accept;
   logic [WORD-1:0]        w_accNext;

   // A start is only honoured while idle; anything else is dropped.
   assign w_accept   = (r_state == S_IDLE) && bus.start;
   assign w_lastIter = (r_counter == c_LAST_ITER);

   // Partial product uses the register contents present before this edge's shift.
   assign w_accNext  = bus.multiplierBit ? (r_acc + bus.multiplicandShifted) : r_acc;

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state decode: one LOAD cycle, WORD_LENGTH CALC cycles, one DONE cycle.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         S_IDLE: begin
            if (bus.start) begin
               w_nextState = S_LOAD;
            end
         end
         S_LOAD: begin
            w_nextState = S_CALC;
         end
         S_CALC: begin
            if (w_lastIter) begin
               w_nextState = S_DONE;
            end
         end
         S_DONE: begin
            w_nextState = S_IDLE;
         end
         default: begin
            w_nextState = S_IDLE;
         end
      endcase
   end

   // Operand capture: held until the next accepted start.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_multiplicandLoad <= '0;
         r_multiplierLoad   <= '0;
      end else if (w_accept) begin
         r_multiplicandLoad <= bus.multiplicand;
         r_multiplierLoad   <= bus.multiplier;
      end
   end

   // Iteration counter: cleared while loading, advanced once per CALC cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_counter <= '0;
      end else if (r_state == S_LOAD) begin
         r_counter <= '0;
      end else if (r_state == S_CALC) begin
         r_counter <= r_counter + COUNT_WIDTH'(1);
      end
   end

   // Accumulator: cleared while loading, conditionally summed in CALC.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_acc <= '0;
      end else if (r_state == S_LOAD) begin
         r_acc <= '0;
      end else if (r_state == S_CALC) begin
         r_acc <= w_accNext;
      end
   end

   // Product register: takes the final sum on the edge that enters DONE, so it
   // is already valid while ready is high, and is held otherwise.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_product <= '0;
      end else if ((r_state == S_CALC) && w_lastIter) begin
         r_product <= w_accNext;
      end
   end

   // Strobes are pure state decodes, so start never reaches an output combinationally
   // and load/shift can never coincide.
   assign bus.load             = (r_state == S_LOAD);
   assign bus.shift            = (r_state == S_CALC);
   assign bus.ready            = (r_state == S_DONE);
   assign bus.busy             = (r_state != S_IDLE);
   assign bus.product          = r_product;
   assign bus.multiplicandLoad = r_multiplicandLoad;
   assign bus.multiplierLoad   = r_multiplierLoad;

endmodule
`default_nettype wire

// File: tb/tb_multiplier_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multiplier_sequencer
//  Description : Bench for multiplier_sequencer. Provides the two shift
//                registers around the sequencer, a timeline model of each
//                operation (a*b appearing a fixed number of edges after the
//                accepting edge) and directed operand cases.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multiplier_sequencer;

   localparam int WL = 4;
   localparam int W  = WL * 2;

   logic clk;
   logic reset;

   multiplier_sequencer_if #(.WORD_LENGTH(WL)) ifc ();

   multiplier_sequencer #(.WORD_LENGTH(WL)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (ifc.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- shift registers surrounding the sequencer --------------
   logic [W-1:0]  lsr;
   logic [WL-1:0] rsr;

   // Left register shifts the multiplicand up, right register shifts the multiplier down.
   always @(posedge clk) begin
      if (reset) begin
         lsr <= '0;
         rsr <= '0;
      end else if (ifc.load) begin
         lsr <= W'(ifc.multiplicandLoad);
         rsr <= ifc.multiplierLoad;
      end else if (ifc.shift) begin
         lsr <= lsr << 1;
         rsr <= rsr >> 1;
      end
   end

   assign ifc.multiplicandShifted = lsr;
   assign ifc.multiplierBit       = rsr[0];

   // ---------------- bookkeeping -------------------------------------------
   int vectors    = 0;
   int miscompares = 0;
   bit chkOn      = 1'b0;
   bit zeroMode   = 1'b0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors = vectors + 1;
      if (act !== exp) begin
         miscompares = miscompares + 1;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   // ---------------- timeline model ----------------------------------------
   // An operation accepted at edge t0 occupies the following WL+2 cycles:
   // load in the first, shift in the next WL, ready in the last, with the
   // product a*b visible from that ready cycle on. The next start can be
   // taken WL+3 edges after t0.
   int           edgeIdx = 0;
   int           t0      = 0;
   bit           active  = 1'b0;
   logic [WL-1:0] expA   = '0;
   logic [WL-1:0] expB   = '0;
   logic [W-1:0]  expProd = '0;

   always @(posedge clk) begin
      edgeIdx <= edgeIdx + 1;
      if (reset) begin
         active  <= 1'b0;
         expA    <= '0;
         expB    <= '0;
         expProd <= '0;
      end else begin
         if (ifc.start && (!active || (edgeIdx + 1 >= t0 + WL + 3))) begin
            active <= 1'b1;
            t0     <= edgeIdx + 1;
            expA   <= ifc.multiplicand;
            expB   <= ifc.multiplier;
         end
         if (active && (edgeIdx + 1 == t0 + WL + 1)) begin
            expProd <= W'(expA) * W'(expB);
         end
      end
   end

   // Cycle-by-cycle comparison of every DUT output against the timeline.
   always @(negedge clk) begin : b_cmp
      int d;
      bit inOp;
      d    = edgeIdx - t0;
      inOp = active && (d >= 0) && (d <= WL + 1);
      if (chkOn) begin
         check("load",  32'(ifc.load),  32'(inOp && d == 0));
         check("shift", 32'(ifc.shift), 32'(inOp && d >= 1 && d <= WL));
         check("ready", 32'(ifc.ready), 32'(inOp && d == WL + 1));
         check("busy",  32'(ifc.busy),  32'(inOp));
         check("product", 32'(ifc.product), 32'(expProd));
         check("multiplicandLoad", 32'(ifc.multiplicandLoad), 32'(expA));
         check("multiplierLoad",   32'(ifc.multiplierLoad),   32'(expB));
         if (ifc.load && ifc.shift) begin
            check("load_shift_exclusive", 32'(1), 32'(0));
         end
         if (zeroMode && ifc.shift) begin
            check("acc_zero", 32'(dut.r_acc), 32'(0));
         end
      end
   end

   // Strobe counters used by the directed cases.
   int readyCnt = 0;
   int loadCnt  = 0;
   int shiftCnt = 0;
   always @(negedge clk) begin
      if (ifc.ready) readyCnt <= readyCnt + 1;
      if (ifc.load)  loadCnt  <= loadCnt + 1;
      if (ifc.shift) shiftCnt <= shiftCnt + 1;
   end

   // ---------------- stimulus helpers --------------------------------------
   task automatic waitReady(input string nm, output bit got);
      got = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (ifc.ready) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) check({nm, "_ready_timeout"}, 32'(0), 32'(1));
   endtask

   task automatic pulseStart(input logic [WL-1:0] a, input logic [WL-1:0] b);
      @(negedge clk);
      ifc.multiplicand = a;
      ifc.multiplier   = b;
      ifc.start        = 1'b1;
      @(negedge clk);
      ifc.start        = 1'b0;
   endtask

   task automatic runOp(input string nm, input logic [WL-1:0] a, input logic [WL-1:0] b,
                        input logic [W-1:0] lit);
      bit got;
      pulseStart(a, b);
      waitReady(nm, got);
      if (got) check({nm, "_product"}, 32'(ifc.product), 32'(lit));
      repeat (2) @(negedge clk);
   endtask

   // ---------------- directed sequence -------------------------------------
   initial begin : b_stim
      bit got;
      int r0, l0, s0, e1, e2;

      reset            = 1'b1;
      ifc.start        = 1'b0;
      ifc.multiplicand = '0;
      ifc.multiplier   = '0;
      repeat (2) @(posedge clk);
      chkOn = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("reset_product", 32'(ifc.product), 32'h00);
      check("reset_busy",    32'(ifc.busy),    32'h0);

      // Basic multiply 5x3, with strobe widths
      r0 = readyCnt; l0 = loadCnt; s0 = shiftCnt;
      runOp("basic_5x3", 4'd5, 4'd3, 8'h0F);
      check("basic_load_cycles",  32'(loadCnt - l0),  32'd1);
      check("basic_shift_cycles", 32'(shiftCnt - s0), 32'd4);
      check("basic_ready_cycles", 32'(readyCnt - r0), 32'd1);

      // Reset for two cycles in the middle of CALC aborts without ready
      r0 = readyCnt;
      pulseStart(4'd5, 4'd3);
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      check("abort_product", 32'(ifc.product), 32'h00);
      check("abort_ready",   32'(ifc.ready),   32'h0);
      check("abort_busy",    32'(ifc.busy),    32'h0);
      check("abort_load",    32'(ifc.load),    32'h0);
      check("abort_shift",   32'(ifc.shift),   32'h0);
      repeat (12) @(negedge clk);
      check("abort_no_ready", 32'(readyCnt - r0), 32'd0);

      // Maximum operands, then a second product; E1 must hold until the second ready
      runOp("max_15x15", 4'd15, 4'd15, 8'hE1);
      pulseStart(4'd9, 4'd6);
      check("hold_E1", 32'(ifc.product), 32'hE1);
      waitReady("max_9x6", got);
      if (got) check("max_9x6_product", 32'(ifc.product), 32'h36);
      repeat (2) @(negedge clk);

      // Zero operands: accumulator never moves
      zeroMode = 1'b1;
      runOp("zero_0x13", 4'd0, 4'd13, 8'h00);
      runOp("zero_11x0", 4'd11, 4'd0, 8'h00);
      zeroMode = 1'b0;

      // Start while busy is ignored
      r0 = readyCnt;
      pulseStart(4'd7, 4'd7);
      @(negedge clk);
      ifc.multiplicand = 4'd2;
      ifc.multiplier   = 4'd2;
      ifc.start        = 1'b1;
      @(negedge clk);
      ifc.start        = 1'b0;
      waitReady("busy_7x7", got);
      if (got) check("busy_7x7_product", 32'(ifc.product), 32'h31);
      repeat (12) @(negedge clk);
      check("busy_single_ready", 32'(readyCnt - r0), 32'd1);

      // Back-to-back with start held high
      @(negedge clk);
      ifc.multiplicand = 4'd3;
      ifc.multiplier   = 4'd4;
      ifc.start        = 1'b1;
      @(negedge clk);
      ifc.multiplicand = 4'd6;
      ifc.multiplier   = 4'd5;
      waitReady("b2b_3x4", got);
      e1 = edgeIdx;
      if (got) check("b2b_3x4_product", 32'(ifc.product), 32'h0C);
      waitReady("b2b_6x5", got);
      e2 = edgeIdx;
      ifc.start = 1'b0;
      if (got) begin
         check("b2b_6x5_product", 32'(ifc.product), 32'h1E);
         check("b2b_ready_spacing", 32'(e2 - e1), 32'd7);
      end
      repeat (10) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   // Global watchdog so the run always terminates.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

endmodule
`default_nettype wire
